// File: rtl/counter_seq_ctrl.sv
// Command sequencer for an external W-bit up/down counter: queues count programs, runs them in order.
// Optional build macro CSEQ_TIMEOUT_EN bounds each RUN phase to TIMEOUT_CYC cycles.
//
// state  | meaning
// IDLE   | waiting for a queued command; pops the FIFO head when present
// LOAD   | one-cycle preload strobe to the counter
// RUN    | counting until target, overflow, abort (or timeout)
// FINISH | one-cycle done pulse with the registered result
module counter_seq_ctrl #(
    parameter int W           = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 300
) (
    input  logic                            clk,
    input  logic                            _reset,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_dir,
    input  logic                            cmd_wrap,
    input  logic [W-1:0]                    cmd_start,
    input  logic [W-1:0]                    cmd_target,
    input  logic                            abort,
    input  logic [W-1:0]                    ctr_value,
    input  logic                            ctr_overflow,
    output logic                            ctr_load,
    output logic [W-1:0]                    ctr_preld_val,
    output logic                            ctr_updown,
    output logic                            ctr_wrapstop,
    output logic                            ctr_en,
    output logic                            busy,
    output logic                            done,
    output logic                            done_ovf,
    output logic                            done_abort,
    output logic [W-1:0]                    done_value,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    typedef struct packed {
        logic         dir;
        logic         wrap;
        logic [W-1:0] start;
        logic [W-1:0] target;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FINISH} state_t;

    cmd_t            fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q;
    cmd_t            act_q;
    state_t          state_q, state_d;
    logic            res_ovf_q, res_ovf_d;
    logic            res_abort_q, res_abort_d;
    logic [W-1:0]    res_value_q, res_value_d;
    logic            push, pop, tmo_tc;

    assign cmd_ready  = (level_q < DEPTH_L);
    assign push       = cmd_valid & cmd_ready;
    assign fifo_level = level_q;
    assign busy       = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= '{dir: cmd_dir, wrap: cmd_wrap,
                                            start: cmd_start, target: cmd_target};
    end

    always_ff @(posedge clk) begin
        if (_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            act_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                act_q    <= fifo_mem_q[rd_ptr_q];
            end
            if (push && !pop)      level_q <= level_q + LW'(1);
            else if (pop && !push) level_q <= level_q - LW'(1);
        end
    end

`ifdef CSEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_INIT = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] tmo_cnt_q;

    // Down-counter reaches zero on the TIMEOUT_CYC-th RUN cycle.
    always_ff @(posedge clk) begin
        if (_reset)                                  tmo_cnt_q <= '0;
        else if (state_q == S_LOAD)                  tmo_cnt_q <= TMO_INIT;
        else if (state_q == S_RUN && tmo_cnt_q != '0) tmo_cnt_q <= tmo_cnt_q - TW'(1);
    end

    assign tmo_tc = (state_q == S_RUN) && (tmo_cnt_q == '0);
`else
    assign tmo_tc = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (_reset) begin
            state_q     <= S_IDLE;
            res_ovf_q   <= 1'b0;
            res_abort_q <= 1'b0;
            res_value_q <= '0;
        end else begin
            state_q     <= state_d;
            res_ovf_q   <= res_ovf_d;
            res_abort_q <= res_abort_d;
            res_value_q <= res_value_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        res_ovf_d     = res_ovf_q;
        res_abort_d   = res_abort_q;
        res_value_d   = res_value_q;
        ctr_load      = 1'b0;
        ctr_preld_val = '0;
        ctr_updown    = 1'b0;
        ctr_wrapstop  = 1'b0;
        ctr_en        = 1'b0;
        done          = 1'b0;
        done_ovf      = 1'b0;
        done_abort    = 1'b0;
        done_value    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                ctr_load      = 1'b1;
                ctr_preld_val = act_q.start;
                ctr_updown    = act_q.dir;
                ctr_wrapstop  = act_q.wrap;
                state_d       = S_RUN;
            end
            S_RUN: begin
                ctr_updown   = act_q.dir;
                ctr_wrapstop = act_q.wrap;
                ctr_en       = (ctr_value != act_q.target) & ~ctr_overflow & ~abort;
                res_value_d  = ctr_value;
                // Natural completion on the last allowed cycle is reported as such, not as timeout.
                if (abort) begin
                    res_abort_d = 1'b1;
                    res_ovf_d   = 1'b0;
                    state_d     = S_FINISH;
                end else if (ctr_overflow) begin
                    res_abort_d = 1'b0;
                    res_ovf_d   = 1'b1;
                    state_d     = S_FINISH;
                end else if (ctr_value == act_q.target) begin
                    res_abort_d = 1'b0;
                    res_ovf_d   = 1'b0;
                    state_d     = S_FINISH;
                end else if (tmo_tc) begin
                    res_abort_d = 1'b1;
                    res_ovf_d   = 1'b0;
                    state_d     = S_FINISH;
                end
            end
            S_FINISH: begin
                done       = 1'b1;
                done_ovf   = res_ovf_q;
                done_abort = res_abort_q;
                done_value = res_value_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a behavioural 8-bit up/down counter closing the loop.
module tb_counter_seq_ctrl;
    localparam int W = 8;
`ifdef CSEQ_TIMEOUT_EN
    localparam int TMO = 20;
`else
    localparam int TMO = 300;
`endif

    logic         clk = 1'b0;
    logic         _reset = 1'b1;
    logic         cmd_valid = 1'b0, cmd_ready;
    logic         cmd_dir = 1'b0, cmd_wrap = 1'b0;
    logic [W-1:0] cmd_start = '0, cmd_target = '0;
    logic         abort = 1'b0;
    logic [W-1:0] ctr_value;
    logic         ctr_overflow;
    logic         ctr_load, ctr_updown, ctr_wrapstop, ctr_en;
    logic [W-1:0] ctr_preld_val;
    logic         busy, done, done_ovf, done_abort;
    logic [W-1:0] done_value;
    logic [2:0]   fifo_level;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int en_cnt = 0;
    int rd_idx = 0;
    int en0;
    logic [9:0] res_a [0:63];

    counter_seq_ctrl #(.W(W), .FIFO_DEPTH(4), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), ._reset(_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_wrap(cmd_wrap),
        .cmd_start(cmd_start), .cmd_target(cmd_target),
        .abort(abort),
        .ctr_value(ctr_value), .ctr_overflow(ctr_overflow),
        .ctr_load(ctr_load), .ctr_preld_val(ctr_preld_val),
        .ctr_updown(ctr_updown), .ctr_wrapstop(ctr_wrapstop), .ctr_en(ctr_en),
        .busy(busy), .done(done), .done_ovf(done_ovf), .done_abort(done_abort),
        .done_value(done_value), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Counter model: stop mode flags overflow while sitting at its limit; wrap mode never does.
    logic [W-1:0] m_val = '0;
    logic         m_up = 1'b0, m_wrap = 1'b1;
    always @(posedge clk) begin
        if (ctr_load) begin
            m_val  <= ctr_preld_val;
            m_up   <= ctr_updown;
            m_wrap <= ctr_wrapstop;
        end else if (ctr_en && !ctr_overflow) begin
            m_val <= m_up ? m_val + 8'd1 : m_val - 8'd1;
        end
    end
    assign ctr_value    = m_val;
    assign ctr_overflow = !m_wrap && (m_up ? (m_val == 8'hFF) : (m_val == 8'h00));

    always @(negedge clk) begin
        if (done) begin
            res_a[done_cnt[5:0]] <= {done_abort, done_ovf, done_value};
            done_cnt <= done_cnt + 1;
        end
        if (ctr_en) en_cnt <= en_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic d, input logic w, input logic [W-1:0] s, input logic [W-1:0] t);
        logic ok;
        ok = 1'b0;
        cmd_dir = d; cmd_wrap = w; cmd_start = s; cmd_target = t;
        cmd_valid = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            ok = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        chk("push_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_done(input int n, input int budget);
        int i;
        i = 0;
        while (done_cnt < n && i < budget) begin
            tick();
            i++;
        end
        chk("done_within_budget", {31'd0, done_cnt >= n}, 32'd1);
    endtask

    task automatic chk_res(input string tag, input logic a, input logic o, input logic [W-1:0] v);
        chk(tag, {22'd0, res_a[rd_idx]}, {22'd0, a, o, v});
        rd_idx++;
    endtask

    initial begin
        tick(); tick();
        _reset = 1'b0;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_level", {29'd0, fifo_level}, 0);
        chk("rst_ready", {31'd0, cmd_ready}, 1);
        chk("rst_outs", {28'd0, ctr_load, ctr_en, done, ctr_updown}, 0);

        // up/stop 10 -> 13
        push_cmd(1'b1, 1'b0, 8'd10, 8'd13);
        chk("t1_level", {29'd0, fifo_level}, 1);
        en0 = en_cnt;
        tick();
        chk("t1_load", {31'd0, ctr_load}, 1);
        chk("t1_preld", {24'd0, ctr_preld_val}, 10);
        chk("t1_mode", {30'd0, ctr_updown, ctr_wrapstop}, 32'd2);
        chk("t1_en_in_load", {31'd0, ctr_en}, 0);
        wait_done(1, 50);
        chk("t1_en_cycles", en_cnt - en0, 3);
        chk("t1_done_pulse", {30'd0, done, busy}, 0);
        chk_res("t1_result", 1'b0, 1'b0, 8'd13);

        // down/wrap 2 -> 254 through zero
        en0 = en_cnt;
        push_cmd(1'b0, 1'b1, 8'd2, 8'd254);
        wait_done(2, 50);
        chk("t2_en_cycles", en_cnt - en0, 4);
        chk_res("t2_result", 1'b0, 1'b0, 8'd254);

        // up/stop 250 -> 5 unreachable: ends on overflow
        en0 = en_cnt;
        push_cmd(1'b1, 1'b0, 8'd250, 8'd5);
        wait_done(3, 50);
        chk("t3_en_cycles", en_cnt - en0, 5);
        chk_res("t3_result", 1'b0, 1'b1, 8'd255);

        // start == target
        en0 = en_cnt;
        push_cmd(1'b1, 1'b0, 8'd77, 8'd77);
        wait_done(4, 50);
        chk("t4_en_cycles", en_cnt - en0, 0);
        chk_res("t4_result", 1'b0, 1'b0, 8'd77);

        // back-to-back queueing: FIFO fills behind a long command
        push_cmd(1'b1, 1'b0, 8'd0, 8'd40);
        push_cmd(1'b1, 1'b0, 8'd100, 8'd103);
        push_cmd(1'b0, 1'b0, 8'd50, 8'd47);
        push_cmd(1'b1, 1'b1, 8'd254, 8'd1);
        push_cmd(1'b1, 1'b0, 8'd7, 8'd9);
        chk("q_level_full", {29'd0, fifo_level}, 4);
        chk("q_ready_full", {31'd0, cmd_ready}, 0);
        push_cmd(1'b1, 1'b0, 8'd20, 8'd22);
        wait_done(10, 400);
        chk_res("q_a", 1'b0, 1'b0, 8'd40);
        chk_res("q_b", 1'b0, 1'b0, 8'd103);
        chk_res("q_c", 1'b0, 1'b0, 8'd47);
        chk_res("q_d", 1'b0, 1'b0, 8'd1);
        chk_res("q_e", 1'b0, 1'b0, 8'd9);
        chk_res("q_f", 1'b0, 1'b0, 8'd22);

        // abort at value 50, next command still runs
        push_cmd(1'b1, 1'b1, 8'd0, 8'd200);
        push_cmd(1'b1, 1'b0, 8'd5, 8'd6);
        for (int i = 0; i < 200 && !(busy && !ctr_load && ctr_value == 8'd50); i++) tick();
        chk("ab_reached", {24'd0, ctr_value}, 50);
        abort = 1'b1;
        #1;
        chk("ab_en_low", {31'd0, ctr_en}, 0);
        tick();
        abort = 1'b0;
        wait_done(12, 100);
        chk_res("ab_result", 1'b1, 1'b0, 8'd50);
        chk_res("ab_next", 1'b0, 1'b0, 8'd6);

        // reset in the middle of RUN with a queued command
        push_cmd(1'b1, 1'b0, 8'd0, 8'd100);
        push_cmd(1'b1, 1'b0, 8'd1, 8'd2);
        for (int i = 0; i < 10; i++) tick();
        chk("mr_busy_before", {31'd0, busy}, 1);
        _reset = 1'b1;
        tick();
        _reset = 1'b0;
        chk("mr_busy", {31'd0, busy}, 0);
        chk("mr_level", {29'd0, fifo_level}, 0);
        chk("mr_outs", {27'd0, ctr_load, ctr_en, done, ctr_updown, ctr_wrapstop}, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("mr_stays_idle", {31'd0, busy}, 0);
        chk("mr_no_done", done_cnt, 12);

`ifdef CSEQ_TIMEOUT_EN
        push_cmd(1'b1, 1'b0, 8'd0, 8'd100);
        wait_done(13, 100);
        chk_res("tmo_result", 1'b1, 1'b0, 8'd19);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
